// File: rtl/fixed_point_mul_scheduler_pkg.sv
// Shared widths, Q-format range limits and the pipeline stage record for the
// shared fixed-point multiplier scheduler.
package fixed_point_mul_scheduler_pkg;

   // Stage records use fixed-width containers so one typedef serves every parameter set
   localparam int PROD_CW = 64;
   localparam int ID_CW   = 8;

   function automatic int calc_w(input int n_bits, input int q_bits);
      return n_bits + q_bits;
   endfunction

   function automatic int calc_id_w(input int n_req);
      return (n_req > 1) ? $clog2(n_req) : 1;
   endfunction

   function automatic longint fx_max(input int n_bits, input int q_bits);
      return (64'sd1 <<< (n_bits + q_bits - 1)) - 64'sd1;
   endfunction

   function automatic longint fx_min(input int n_bits, input int q_bits);
      return -(64'sd1 <<< (n_bits + q_bits - 1));
   endfunction

   typedef struct packed {
      logic                      vld;
      logic [ID_CW-1:0]          id;
      logic signed [PROD_CW-1:0] prod;
   } mul_stage_t;

endpackage

// File: rtl/fixed_point_mul_scheduler_if.sv
// Requester operand bus and tagged result stream of the multiplier scheduler.
interface fixed_point_mul_scheduler_if
   import fixed_point_mul_scheduler_pkg::*;
#(
   parameter int N_REQ_P  = 4,
   parameter int N_BITS_P = 8,
   parameter int Q_BITS_P = 8
);
   localparam int W    = calc_w(N_BITS_P, Q_BITS_P);
   localparam int ID_W = calc_id_w(N_REQ_P);

   logic [N_REQ_P-1:0]         req_valid;
   logic [N_REQ_P-1:0]         req_ready;
   logic [N_REQ_P-1:0][W-1:0]  req_a;
   logic [N_REQ_P-1:0][W-1:0]  req_b;
   logic                       res_valid;
   logic                       res_ready;
   logic [ID_W-1:0]            res_id;
   logic [W-1:0]               res_data;
   logic                       res_overflow;
   logic                       busy;

   modport master (
      output req_valid, req_a, req_b, res_ready,
      input  req_ready, res_valid, res_id, res_data, res_overflow, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_id, res_data, res_overflow, busy
   );
endinterface

// File: rtl/fixed_point_mul_pipe.sv
// Stallable multiply / round-half-up / range-check pipeline.
// FIXED_POINT_SATURATION_EN clamps out-of-range results; otherwise they wrap.
module fixed_point_mul_pipe
   import fixed_point_mul_scheduler_pkg::*;
#(
   parameter int  N_BITS_P      = 8,
   parameter int  Q_BITS_P      = 8,
   parameter int  MUL_LATENCY_P = 3,
   parameter int  ID_W          = 2,
   localparam int W             = calc_w(N_BITS_P, Q_BITS_P)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            in_vld,
   input  logic [ID_W-1:0] in_id,
   input  logic [W-1:0]    in_a,
   input  logic [W-1:0]    in_b,
   output logic            out_vld,
   output logic [ID_W-1:0] out_id,
   output logic [W-1:0]    out_data,
   output logic            out_ovf,
   output logic            busy
);
   localparam longint MAXV = fx_max(N_BITS_P, Q_BITS_P);
   localparam longint MINV = fx_min(N_BITS_P, Q_BITS_P);

   logic [MUL_LATENCY_P:0]    vld_pipe;
   logic                      op_vld;
   logic [ID_W-1:0]           op_id;
   logic signed [W-1:0]       op_a, op_b;
   logic signed [2*W-1:0]     prod_w;
   mul_stage_t                s_in, s_last;
   logic signed [PROD_CW-1:0] rnd, sel;
   logic                      ovf;
   logic                      unused_bits;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         op_vld <= 1'b0;
         op_id  <= '0;
         op_a   <= '0;
         op_b   <= '0;
      end else if (en) begin
         op_vld <= in_vld;
         op_id  <= in_id;
         op_a   <= in_a;
         op_b   <= in_b;
      end

   assign prod_w = op_a * op_b;
   assign s_in   = '{vld: op_vld, id: ID_CW'(op_id), prod: PROD_CW'(prod_w)};
   assign vld_pipe[0] = op_vld;

   generate
      if (MUL_LATENCY_P > 1) begin : g_mid
         mul_stage_t mid [MUL_LATENCY_P-1:1];
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               for (int k = 1; k < MUL_LATENCY_P; k++) mid[k] <= '0;
            end else if (en) begin
               mid[1] <= s_in;
               for (int k = 2; k < MUL_LATENCY_P; k++) mid[k] <= mid[k-1];
            end
         for (genvar k = 1; k < MUL_LATENCY_P; k++) begin : g_v
            assign vld_pipe[k] = mid[k].vld;
         end
         assign s_last = mid[MUL_LATENCY_P-1];
      end else begin : g_direct
         assign s_last = s_in;
      end
   endgenerate

   // Product magnitude stays below 2^(2W-1), so adding the half-LSB cannot overflow the container
   assign rnd = (s_last.prod + (64'sd1 <<< (Q_BITS_P - 1))) >>> Q_BITS_P;
   assign ovf = (rnd > MAXV) || (rnd < MINV);
`ifdef FIXED_POINT_SATURATION_EN
   assign sel = !ovf ? rnd : (rnd[PROD_CW-1] ? MINV : MAXV);
`else
   assign sel = rnd;
`endif
   assign unused_bits = ^{sel[PROD_CW-1:W], s_last.id[ID_CW-1:ID_W]};

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_vld  <= 1'b0;
         out_id   <= '0;
         out_data <= '0;
         out_ovf  <= 1'b0;
      end else if (en) begin
         out_vld  <= s_last.vld;
         out_id   <= s_last.id[ID_W-1:0];
         out_data <= sel[W-1:0];
         out_ovf  <= s_last.vld & ovf;
      end

   assign vld_pipe[MUL_LATENCY_P] = out_vld;
   assign busy = |vld_pipe;

endmodule

// File: rtl/fixed_point_mul_scheduler.sv
// Round-robin arbiter sharing one pipelined Q-format multiplier between requesters.
// Build option FIXED_POINT_SATURATION_EN selects saturating instead of wrapping results.
module fixed_point_mul_scheduler
   import fixed_point_mul_scheduler_pkg::*;
#(
   parameter int N_REQ_P       = 4,
   parameter int N_BITS_P      = 8,
   parameter int Q_BITS_P      = 8,
   parameter int MUL_LATENCY_P = 3
) (
   input logic                        clk,
   input logic                        rst,
   fixed_point_mul_scheduler_if.slave bus
);
   localparam int ID_W = calc_id_w(N_REQ_P);

   logic [ID_W-1:0]    last_grant, gnt_id, idx;
   logic [N_REQ_P-1:0] grant;
   logic               gnt_any, advance, xfer;
   int                 idx_i;

   assign advance = !bus.res_valid || bus.res_ready;

   // First valid requester after the last winner, wrapping at N_REQ_P-1
   always_comb begin
      grant   = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      idx_i   = 0;
      idx     = '0;
      for (int k = 1; k <= N_REQ_P; k++) begin
         idx_i = (int'(last_grant) + k) % N_REQ_P;
         idx   = ID_W'(idx_i);
         if (!gnt_any && bus.req_valid[idx]) begin
            grant[idx] = 1'b1;
            gnt_id     = idx;
            gnt_any    = 1'b1;
         end
      end
   end

   assign bus.req_ready = (rst || !advance) ? '0 : grant;
   assign xfer          = gnt_any && advance && !rst;

   always_ff @(posedge clk or posedge rst)
      if (rst)       last_grant <= ID_W'(N_REQ_P - 1);
      else if (xfer) last_grant <= gnt_id;

   fixed_point_mul_pipe #(
      .N_BITS_P      (N_BITS_P),
      .Q_BITS_P      (Q_BITS_P),
      .MUL_LATENCY_P (MUL_LATENCY_P),
      .ID_W          (ID_W)
   ) u_pipe (
      .clk      (clk),
      .rst      (rst),
      .en       (advance),
      .in_vld   (xfer),
      .in_id    (gnt_id),
      .in_a     (bus.req_a[gnt_id]),
      .in_b     (bus.req_b[gnt_id]),
      .out_vld  (bus.res_valid),
      .out_id   (bus.res_id),
      .out_data (bus.res_data),
      .out_ovf  (bus.res_overflow),
      .busy     (bus.busy)
   );

endmodule
